oclib_fpga_serial_stream: RTL and testbench
===========================================

Name: oclib_fpga_serial_stream

Overview:
Downstream consumer of the FPGA serial-number stage. Waits for the serial value to settle after reset, then latches it. Emits it as a framed, byte-wide valid/ready stream: header, serial bytes LS-first, CRC-8. Feeds the board-management UART/CSR path, which reports device identity to the host. Sends one frame automatically after settling, and another on each host request.

Parameters:
SerialBits, 96, width of incoming serial; must be >= 8.
SettleCycles, 128, cycles after reset release before serial is sampled; must be >= SerialBits+2 and >= 1.
HeaderByte, 8'hA5, first byte of every frame.
(derived) NumBytes = ceil(SerialBits/8); MS byte zero-padded.

Ports:
clock  input  1  sole clock.
reset_n  input  1  asynchronous, active-low reset.
serial  input  SerialBits  serial number from upstream; stable once settled.
request  input  1  single-cycle pulse: send another frame.
out_data  output  8  stream byte.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts byte when out_valid && out_ready.
out_last  output  1  high with the CRC byte (final byte of frame).
serial_ready  output  1  high once serial_latched is captured; stays high until reset.
serial_latched  output  SerialBits  captured serial value.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`. While reset_n=0, all state is cleared:
  - out_valid=0, out_last=0, out_data=0
  - serial_ready=0, serial_latched=0
  - settle counter=0, pending=0, crc=0, state=SETTLE
- States: SETTLE, IDLE, HDR, DATA, CRC.
- SETTLE:
  - Counter increments each clock.
  - On the edge where counter==SettleCycles-1: latch serial into serial_latched, set serial_ready=1, set pending=1, go to IDLE.
  - serial is sampled exactly once per reset.
- IDLE:
  - If pending: clear pending, load crc=0, byte index=0, go to HDR. out_valid rises on this same edge.
  - First out_valid therefore appears SettleCycles+1 rising edges after reset_n deasserts.
- HDR:
  - out_data=HeaderByte, out_valid=1.
  - On accept: go to DATA with index 0. The header is not included in the CRC.
- DATA:
  - out_data=serial_latched byte[index], LS byte first; bits beyond SerialBits read as 0.
  - On accept: crc <= crc8(crc, out_data); index++.
  - On accepting index NumBytes-1: go to CRC.
- CRC:
  - out_data=crc (final value), out_last=1.
  - On accept: out_valid=0, out_last=0, go to IDLE.
  - No idle bubble is required inside a frame; bytes are back-to-back when out_ready stays high.
- CRC-8 algorithm: poly 0x07, init 0x00, no reflection, no final XOR (CRC-8/SMBUS). Data bytes are processed MSB-first.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_valid and out_last hold stable.
  - out_valid never drops without an accept.
  - out_ready is ignored while out_valid=0.
- request handling:
  - request in any state sets pending=1. pending is a single bit, so multiple requests before service collapse to one extra frame.
  - A request during SETTLE merges with the automatic frame; exactly one frame is sent.
  - A request on the same edge the CRC byte is accepted yields one more frame, starting from IDLE.
- Frame length: NumBytes+2 bytes.
- Reset mid-frame: the frame is abandoned immediately. out_valid drops asynchronously. After release the block re-enters SETTLE, re-samples serial and sends a fresh frame.
- serial changes after the latch have no effect.

Test Plan:
1. SerialBits=32, SettleCycles=40, serial=32'h01234567, out_ready=1 always -> first out_valid at edge 41 after release. Bytes A5,67,45,23,01,E7 on consecutive cycles, out_last only on E7. serial_ready=1, serial_latched=32'h01234567.
2. Same setup, out_ready toggled pseudo-randomly (including long low stretches mid-DATA and on CRC) -> identical byte sequence. out_data, out_valid and out_last are stable on every stalled cycle.
3. Default SerialBits=96, serial=96'h0123456789ABCDEF00112233 -> 14-byte frame: A5, then 33,22,11,00,EF,CD,AB,89,67,45,23,01, then CRC equal to the reference-model CRC-8/SMBUS of those 12 bytes, with out_last on the CRC byte.
4. Request scenarios:
   - Request pulsed in SETTLE -> exactly one frame.
   - Three requests during a frame -> exactly one additional frame after it.
   - Request on the same cycle as the CRC accept -> one additional frame.
5. SerialBits=20, serial=20'hABCDE -> bytes A5,DE,BC,0A,crc; the padded MS byte is 0x0A.
6. Assert reset_n=0 during DATA, change serial to 32'hDEADBEEF, release -> out_valid drops immediately. After SettleCycles+1 edges, a new frame starts A5,EF,BE,AD,DE with a fresh CRC.

Source files
------------

// File: rtl/oclib_fpga_serial_stream_if.sv
// Byte-wide valid/ready stream carrying the framed serial number.
interface oclib_fpga_serial_stream_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/oclib_fpga_serial_stream.sv
// Latches the FPGA serial number once it has settled after reset and emits it as a
// framed byte stream: header, serial bytes LS-first, CRC-8/SMBUS over the serial bytes.
module oclib_fpga_serial_stream #(
  parameter int unsigned SerialBits   = 96,
  parameter int unsigned SettleCycles = 128,
  parameter logic [7:0]  HeaderByte   = 8'hA5
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [SerialBits-1:0]         serial,
  input  logic                          request,
  oclib_fpga_serial_stream_if.master    stream,
  output logic                          serial_ready,
  output logic [SerialBits-1:0]         serial_latched
);

  localparam int unsigned NumBytes = (SerialBits + 7) / 8;
  localparam int unsigned PadBits  = NumBytes * 8;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned CntW     = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumBytes - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SettleCycles - 1);

  localparam logic [2:0] ST_SETTLE = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_HDR    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CRC    = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [CntW-1:0]       cnt_q,     cnt_d;
  logic                  pending_q, pending_d;
  logic [7:0]            crc_q,     crc_d;
  logic [IdxW-1:0]       idx_q,     idx_d;
  logic [SerialBits-1:0] latched_q, latched_d;
  logic                  sready_q,  sready_d;
  logic [7:0]            data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  last_q,    last_d;

  logic [PadBits-1:0]    padded_c;
  logic                  accept_c;

  // Zero-extend to whole bytes so the MS byte reads padded with zeros.
  assign padded_c = PadBits'(latched_q);
  assign accept_c = valid_q && stream.out_ready;

  function automatic logic [7:0] byte_at(input logic [PadBits-1:0] vec, input logic [IdxW-1:0] i);
    return vec[i*8 +: 8];
  endfunction

  // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    crc_d     = crc_q;
    idx_d     = idx_q;
    latched_d = latched_q;
    sready_d  = sready_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;

    case (state_q)
      ST_SETTLE: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          latched_d = serial;
          sready_d  = 1'b1;
          pending_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          crc_d     = 8'h00;
          idx_d     = '0;
          data_d    = HeaderByte;
          valid_d   = 1'b1;
          last_d    = 1'b0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          idx_d   = '0;
          data_d  = byte_at(padded_c, IdxW'(0));
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          crc_d = crc8_upd(crc_q, data_q);
          if (idx_q == IdxLast) begin
            data_d  = crc_d;
            last_d  = 1'b1;
            state_d = ST_CRC;
          end else begin
            idx_d  = idx_q + IdxW'(1);
            data_d = byte_at(padded_c, idx_q + IdxW'(1));
          end
        end
      end
      ST_CRC: begin
        if (accept_c) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = 8'h00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    // A request in any state (even the servicing edge) leaves one frame owed.
    if (request) pending_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      crc_q     <= 8'h00;
      idx_q     <= '0;
      latched_q <= '0;
      sready_q  <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      crc_q     <= crc_d;
      idx_q     <= idx_d;
      latched_q <= latched_d;
      sready_q  <= sready_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;
  assign serial_ready     = sready_q;
  assign serial_latched   = latched_q;

endmodule

// File: tb/tb_oclib_fpga_serial_stream.sv
// Directed bench for oclib_fpga_serial_stream: three widths, scoreboarded frames,
// settle timing, stall stability, request merging and mid-frame reset.
module tb_oclib_fpga_serial_stream;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request;
  logic        out_ready;
  logic [31:0] ser32;
  logic [95:0] ser96;
  logic [19:0] ser20;
  logic [1:0]  sel;

  logic        rdy32, rdy96, rdy20;
  logic [31:0] lat32;
  logic [95:0] lat96;
  logic [19:0] lat20;

  logic [7:0]  obs_data;
  logic        obs_valid, obs_last;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];

  always #5 clock = ~clock;

  oclib_fpga_serial_stream_if if32 ();
  oclib_fpga_serial_stream_if if96 ();
  oclib_fpga_serial_stream_if if20 ();

  assign if32.out_ready = out_ready;
  assign if96.out_ready = out_ready;
  assign if20.out_ready = out_ready;

  oclib_fpga_serial_stream #(.SerialBits(32), .SettleCycles(40)) u32 (
    .clock(clock), .reset_n(reset_n), .serial(ser32), .request(request),
    .stream(if32), .serial_ready(rdy32), .serial_latched(lat32));

  oclib_fpga_serial_stream u96 (
    .clock(clock), .reset_n(reset_n), .serial(ser96), .request(request),
    .stream(if96), .serial_ready(rdy96), .serial_latched(lat96));

  oclib_fpga_serial_stream #(.SerialBits(20), .SettleCycles(24)) u20 (
    .clock(clock), .reset_n(reset_n), .serial(ser20), .request(request),
    .stream(if20), .serial_ready(rdy20), .serial_latched(lat20));

  always_comb begin
    obs_data  = if32.out_data;
    obs_valid = if32.out_valid;
    obs_last  = if32.out_last;
    case (sel)
      2'd1: begin obs_data = if96.out_data; obs_valid = if96.out_valid; obs_last = if96.out_last; end
      2'd2: begin obs_data = if20.out_data; obs_valid = if20.out_valid; obs_last = if20.out_last; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: feedback bit = crc MSB xor data bit, data MSB first.
  function automatic logic [7:0] ref_crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic push_frame(input logic [95:0] val, input int nbytes);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    sb.push_back({1'b0, 8'hA5});
    for (int i = 0; i < nbytes; i++) begin
      b = val[i*8 +: 8];
      sb.push_back({1'b0, b});
      c = ref_crc8(c, b);
    end
    sb.push_back({1'b1, c});
  endtask

  // Drain the scoreboard against the observed stream; checks holds on stalled cycles.
  task automatic run_frames(input int budget, input bit rnd, input int req_lo, input int nreq,
                            input bit req_last, output int cycles);
    logic [8:0] exp;
    logic [7:0] hd;
    logic       hl;
    bit         stalled;
    bit         done;
    int         k;
    stalled = 1'b0;
    done    = 1'b0;
    k       = 0;
    hd      = 8'h00;
    hl      = 1'b0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clock);
      if (stalled) begin
        check("hold_data", 96'(obs_data), 96'(hd));
        check("hold_valid", 96'(obs_valid), 96'(1));
        check("hold_last", 96'(obs_last), 96'(hl));
      end
      if (rnd) out_ready = ((k % 23) inside {[10:17]}) ? 1'b0 : ($urandom_range(0, 99) < 60);
      else     out_ready = 1'b1;
      request = (k >= req_lo) && (k < req_lo + nreq);
      stalled = obs_valid && !out_ready;
      hd      = obs_data;
      hl      = obs_last;
      if (obs_valid && out_ready) begin
        exp = sb.pop_front();
        check("data", 96'(obs_data), 96'(exp[7:0]));
        check("last", 96'(obs_last), 96'(exp[8]));
        if (req_last && exp[8] && !done) begin
          request = 1'b1;
          done    = 1'b1;
        end
      end
      k++;
    end
    check("frame_done", 96'(sb.size()), 96'(0));
    cycles = k;
    @(negedge clock);
    request   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic expect_quiet(input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (obs_valid) seen = 1'b1;
    end
    check("no_extra_frame", 96'(seen), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n   = 1'b0;
    request   = 1'b0;
    out_ready = 1'b1;
    sel       = 2'd0;
    ser32     = 32'h01234567;
    ser96     = 96'h0123456789ABCDEF00112233;
    ser20     = 20'hABCDE;

    repeat (3) @(negedge clock);
    check("rst_valid", 96'(if32.out_valid), 96'(0));
    check("rst_data", 96'(if32.out_data), 96'(0));
    check("rst_last", 96'(if32.out_last), 96'(0));
    check("rst_sready", 96'({rdy32, rdy96, rdy20}), 96'(0));
    check("rst_latched", lat96 | 96'(lat32) | 96'(lat20), 96'(0));

    // Release, pulse a request during SETTLE, then check first-valid timing.
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock) request = 1'b1;
    @(negedge clock) request = 1'b0;
    repeat (34) @(posedge clock);
    #1 check("settle_no_valid_e40", 96'(if32.out_valid), 96'(0));
    check("sready_e40", 96'(rdy32), 96'(1));
    @(posedge clock);
    #1 check("first_valid_e41", 96'(if32.out_valid), 96'(1));
    push_frame(96'(ser32), 4);
    run_frames(50, 1'b0, -1, 0, 1'b0, cyc);
    check("b2b_cycles", 96'(cyc), 96'(6));
    expect_quiet(30);

    // 96-bit default instance with stalls.
    sel = 2'd1;
    push_frame(ser96, 12);
    run_frames(600, 1'b1, -1, 0, 1'b0, cyc);
    check("latched32", 96'(lat32), 96'(32'h01234567));
    check("latched96", lat96, 96'h0123456789ABCDEF00112233);
    check("latched20", 96'(lat20), 96'(20'hABCDE));
    check("sready_all", 96'({rdy32, rdy96, rdy20}), 96'(3'b111));

    // 20-bit instance: padded MS byte, stalled.
    sel = 2'd2;
    ser32 = 32'hFFFF0000;
    push_frame(96'(ser20), 3);
    request = 1'b1;
    run_frames(300, 1'b1, -1, 0, 1'b0, cyc);
    expect_quiet(20);

    // Three requests mid-frame collapse to one extra frame.
    sel = 2'd0;
    push_frame(96'(32'h01234567), 4);
    push_frame(96'(32'h01234567), 4);
    request = 1'b1;
    run_frames(100, 1'b0, 3, 3, 1'b0, cyc);
    expect_quiet(30);

    // Request coinciding with the CRC accept yields one more frame.
    push_frame(96'(32'h01234567), 4);
    push_frame(96'(32'h01234567), 4);
    request = 1'b1;
    run_frames(300, 1'b1, -1, 0, 1'b1, cyc);
    expect_quiet(30);

    // Reset in the middle of DATA.
    request = 1'b1;
    @(negedge clock) request = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("in_data_valid", 96'(if32.out_valid), 96'(1));
    @(negedge clock);
    check("in_data_byte", 96'(if32.out_data), 96'(8'h45));
    reset_n = 1'b0;
    #1;
    check("async_drop_valid", 96'(if32.out_valid), 96'(0));
    check("async_drop_last", 96'(if32.out_last), 96'(0));
    check("async_sready", 96'(rdy32), 96'(0));
    check("async_latched", 96'(lat32), 96'(0));
    sb.delete();
    ser32 = 32'hDEADBEEF;
    @(negedge clock) reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1 check("resettle_no_valid", 96'(if32.out_valid), 96'(0));
    @(posedge clock);
    #1 check("resettle_valid", 96'(if32.out_valid), 96'(1));
    push_frame(96'(32'hDEADBEEF), 4);
    run_frames(50, 1'b0, -1, 0, 1'b0, cyc);
    check("relatched32", 96'(lat32), 96'(32'hDEADBEEF));
    expect_quiet(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
